linear_layer_engine: RTL and testbench
======================================

Name: linear_layer_engine

Overview:
Parametrised fully-connected (linear) layer engine for the KWS inference datapath. It computes OUT_LEN outputs, each the dot product of a locally buffered input vector with one row of weights. Weights are read word-by-word from the weight SRAM through a Wishbone master port. Arithmetic is signed fixed-point with a saturating output, and results are streamed out under a valid/ready handshake.

Parameters:
DATA_W, 32, width of inputs, weights, bias and outputs (signed two's complement)
FRAC_W, 24, fractional bits (default format 1.7.24)
IN_LEN, 20, input vector length (2..256)
OUT_LEN, 10, number of outputs (1..256)
GUARD_W, 8, extra accumulator MSBs; ACC_W = DATA_W + GUARD_W
WEIGHT_BASE, 0, SRAM word address of weight W[0][0]

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  one-cycle pulse; begins a layer evaluation
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse after the last output handshake
in_we  in  1  input buffer write strobe
in_addr  in  8  input buffer index, 0..IN_LEN-1
in_data  in  DATA_W  input element
wbm_cyc_o  out  1  Wishbone cycle
wbm_stb_o  out  1  Wishbone strobe
wbm_we_o  out  1  tied 0 (read only)
wbm_sel_o  out  4  4'b1111 during a request, else 0
wbm_adr_o  out  32  word address
wbm_dat_i  in  32  read data (low DATA_W bits used)
wbm_ack_i  in  1  Wishbone acknowledge
out_valid  out  1  output word valid
out_ready  in  1  downstream accepts output
out_data  out  DATA_W  saturated result
out_idx  out  8  output index o

Behaviour:
- Reset: busy=0, done=0, out_valid=0, out_data=0, out_idx=0, wbm_cyc_o/stb_o=0, wbm_sel_o=0, wbm_adr_o=0, state=IDLE. Input buffer contents are not reset.
- Input buffer: IN_LEN x DATA_W registers, written when in_we=1 and state=IDLE. Writes while busy are ignored. Writes with in_addr >= IN_LEN are ignored.
- start is accepted only in IDLE; it is ignored while busy.
- States:
  - IDLE: on start, clear o and i and go to FETCH.
  - FETCH: drive cyc=stb=1, sel=1111, adr = WEIGHT_BASE + o*IN_LEN + i. Hold the request until wbm_ack_i. On ack, register wbm_dat_i, drop cyc/stb next cycle and go to MAC.
  - MAC: compute p = in_buf[i] * w as a 2*DATA_W signed product. Then acc += sign-extend(p >>> FRAC_W) to ACC_W, using arithmetic shift with truncation toward -inf. If i == IN_LEN-1, go to OUT (BIAS when the bias feature is compiled in); else increment i and go to FETCH.
  - OUT: register out_data = sat(acc), out_idx = o, out_valid=1. Hold all three stable until out_ready=1. On the handshake cycle, clear acc and i. If o == OUT_LEN-1, pulse done and go to IDLE; else increment o and go to FETCH.
- acc is cleared at start and after each output.
- Saturation: if acc > 2^(DATA_W-1)-1, output 0x7FFF..; if acc < -2^(DATA_W-1), output 0x8000..; otherwise output acc[DATA_W-1:0].
- No new Wishbone request is issued while out_valid=1 (full backpressure).
- One outstanding transaction at most. Address wraps modulo 2^32 (unchecked).
- Latency per weight with a zero-wait slave (ack the cycle after stb): 3 cycles (FETCH, ack, MAC).
- Asynchronous reset during any state aborts the evaluation: cyc/stb drop immediately, out_valid drops, and no done pulse is generated.
- done and start in the same cycle cannot occur (start is ignored in non-IDLE states).

Optional Feature:
Macro LINEAR_LAYER_BIAS_EN.
- Defined: the BIAS state follows the last MAC of each output. It issues a read at WEIGHT_BASE + OUT_LEN*IN_LEN + o, sign-extends the value to ACC_W, adds it to acc, then goes to OUT. Bias is in the same Q format as outputs.
- Undefined: no BIAS state, no bias read, MAC goes directly to OUT. Total Wishbone reads per layer = OUT_LEN*IN_LEN.

Test Plan:
- IN_LEN=4, OUT_LEN=2, all inputs 0x01000000 (1.0), all weights 0x00800000 (0.5), zero-wait slave -> outputs 0x02000000 at idx 0 and 1. Exactly 8 reads at addresses 0..7. done pulses once.
- Inputs 0xFF000000 (-1.0), weights 0x00400000 (0.25) -> outputs 0xFF000000. Inputs 0x00000001, weights 0x00000001 -> 0x00000000 (truncation).
- Inputs 0x64000000 (100.0), weights 0x64000000 -> 0x7FFFFFFF. Weights 0x9C000000 (-100.0) -> 0x80000000.
- Hold out_ready=0 for 5 cycles at first output -> out_valid, out_data and out_idx are stable; no wbm_stb_o asserted. Release -> second output proceeds. Slave with 3-cycle ack delay -> stb held and results unchanged.
- Assert rst_n=0 mid-FETCH of output 1 -> cyc/stb/out_valid are 0 asynchronously. A new start after release produces correct results from o=0. start or in_we while busy -> ignored.
- With LINEAR_LAYER_BIAS_EN, bias words 0x01000000 at addresses 8 and 9 (first test) -> outputs 0x03000000, 10 reads total.

Source files
------------

// File: rtl/linear_layer_engine.sv
// linear_layer_engine: fully-connected layer engine. Each output is the dot
// product of the local input buffer with one weight row. Weights are fetched
// one word at a time over a Wishbone read-only master, and results are
// streamed out under valid/ready with signed saturation.
// Optional feature macro: LINEAR_LAYER_BIAS_EN. When it is defined, each
// output gets one bias read at WEIGHT_BASE + OUT_LEN*IN_LEN + o.
module linear_layer_engine #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned FRAC_W      = 24,
  parameter int unsigned IN_LEN      = 20,
  parameter int unsigned OUT_LEN     = 10,
  parameter int unsigned GUARD_W     = 8,
  parameter int unsigned WEIGHT_BASE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic              in_we,
  input  logic [7:0]        in_addr,
  input  logic [DATA_W-1:0] in_data,
  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  output logic              wbm_we_o,
  output logic [3:0]        wbm_sel_o,
  output logic [31:0]       wbm_adr_o,
  input  logic [31:0]       wbm_dat_i,
  input  logic              wbm_ack_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [7:0]        out_idx
);

  localparam int unsigned ACC_W  = DATA_W + GUARD_W;
  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned IDX_W  = (IN_LEN > 1) ? $clog2(IN_LEN) : 1;
  localparam int unsigned ADR_W  = 32;

`ifdef LINEAR_LAYER_BIAS_EN
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_MAC, S_OUT, S_BIAS} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_MAC, S_OUT} state_t;
`endif

  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         i_q, i_d;
  logic [7:0]               o_q, o_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [DATA_W-1:0]        w_q, w_d;
  logic [ADR_W-1:0]         w_addr_q, w_addr_d;
  logic                     cyc_q, cyc_d;
  logic [ADR_W-1:0]         adr_q, adr_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     out_valid_q, out_valid_d;
  logic [DATA_W-1:0]        out_data_q, out_data_d;
  logic [7:0]               out_idx_q, out_idx_d;

  logic [DATA_W-1:0]        in_buf [IN_LEN];
  logic                     in_wr_ok;

  logic signed [DATA_W-1:0] mac_x;
  logic signed [DATA_W-1:0] mac_w;
  logic signed [PROD_W-1:0] mac_p;
  logic signed [PROD_W-1:0] mac_p_sh;
  logic signed [ACC_W-1:0]  mac_term;
  logic [ACC_W-DATA_W:0]    acc_top;
  logic [DATA_W-1:0]        sat_val;

`ifdef LINEAR_LAYER_BIAS_EN
  logic signed [DATA_W-1:0] bias_w;
  logic [ADR_W-1:0]         bias_addr;
  assign bias_w    = wbm_dat_i[DATA_W-1:0];
  assign bias_addr = ADR_W'(WEIGHT_BASE) + ADR_W'(OUT_LEN * IN_LEN) + ADR_W'(o_q);
`endif

  // Input buffer writes are accepted only while idle and only for valid indices
  assign in_wr_ok = in_we && (state_q == S_IDLE) && (9'(in_addr) < 9'(IN_LEN));

  // Input buffer storage (deliberately not reset)
  always_ff @(posedge clk) begin
    if (in_wr_ok) begin
      in_buf[in_addr[IDX_W-1:0]] <= in_data;
    end
  end

  // Fixed-point product, arithmetic shift (floor), then fit to accumulator width
  assign mac_x    = in_buf[i_q];
  assign mac_w    = w_q;
  assign mac_p    = PROD_W'(mac_x) * PROD_W'(mac_w);
  assign mac_p_sh = mac_p >>> FRAC_W;
  assign mac_term = ACC_W'(mac_p_sh);

  // Saturate: in range only when all guard bits match the output sign bit
  assign acc_top = acc_q[ACC_W-1:DATA_W-1];
  always_comb begin
    sat_val = acc_q[DATA_W-1:0];
    if (acc_top != '0 && acc_top != '1) begin
      if (acc_q[ACC_W-1]) begin
        sat_val = {1'b1, {(DATA_W-1){1'b0}}};
      end else begin
        sat_val = {1'b0, {(DATA_W-1){1'b1}}};
      end
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    o_d         = o_q;
    acc_d       = acc_q;
    w_d         = w_q;
    w_addr_d    = w_addr_q;
    cyc_d       = cyc_q;
    adr_d       = adr_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_FETCH;
          i_d      = '0;
          o_d      = '0;
          acc_d    = '0;
          w_addr_d = ADR_W'(WEIGHT_BASE);
          adr_d    = ADR_W'(WEIGHT_BASE);
          cyc_d    = 1'b1;
          busy_d   = 1'b1;
        end
      end

      // Weights are stored row-major, so the read address simply advances by one
      S_FETCH: begin
        if (wbm_ack_i) begin
          w_d      = wbm_dat_i[DATA_W-1:0];
          w_addr_d = w_addr_q + ADR_W'(1);
          cyc_d    = 1'b0;
          state_d  = S_MAC;
        end
      end

      S_MAC: begin
        acc_d = acc_q + mac_term;
        if (i_q == IDX_W'(IN_LEN - 1)) begin
`ifdef LINEAR_LAYER_BIAS_EN
          state_d = S_BIAS;
          cyc_d   = 1'b1;
          adr_d   = bias_addr;
`else
          state_d = S_OUT;
`endif
        end else begin
          i_d     = i_q + IDX_W'(1);
          state_d = S_FETCH;
          cyc_d   = 1'b1;
          adr_d   = w_addr_q;
        end
      end

`ifdef LINEAR_LAYER_BIAS_EN
      S_BIAS: begin
        if (wbm_ack_i) begin
          acc_d   = acc_q + ACC_W'(bias_w);
          cyc_d   = 1'b0;
          state_d = S_OUT;
        end
      end
`endif

      // First cycle loads the result; it is then held until the handshake
      S_OUT: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_data_d  = sat_val;
          out_idx_d   = o_q;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          acc_d       = '0;
          i_d         = '0;
          if (o_q == 8'(OUT_LEN - 1)) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            o_d     = o_q + 8'd1;
            state_d = S_FETCH;
            cyc_d   = 1'b1;
            adr_d   = w_addr_q;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any evaluation in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      i_q         <= '0;
      o_q         <= '0;
      acc_q       <= '0;
      w_q         <= '0;
      w_addr_q    <= '0;
      cyc_q       <= 1'b0;
      adr_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      o_q         <= o_d;
      acc_q       <= acc_d;
      w_q         <= w_d;
      w_addr_q    <= w_addr_d;
      cyc_q       <= cyc_d;
      adr_q       <= adr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = 1'b0;
  assign wbm_sel_o = {4{cyc_q}};
  assign wbm_adr_o = adr_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;

endmodule

// File: tb/tb_linear_layer_engine.sv
// Scoreboard bench for linear_layer_engine (IN_LEN=4, OUT_LEN=2) with a
// Wishbone weight-memory slave model of configurable ack latency.
`timescale 1ns/1ps
module tb_linear_layer_engine;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned IN_LEN  = 4;
  localparam int unsigned OUT_LEN = 2;
`ifdef LINEAR_LAYER_BIAS_EN
  localparam int unsigned RD_PER_OUT = IN_LEN + 1;
  localparam logic [31:0] BIAS_ADD   = 32'h0100_0000;
`else
  localparam int unsigned RD_PER_OUT = IN_LEN;
  localparam logic [31:0] BIAS_ADD   = 32'h0000_0000;
`endif

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              busy;
  logic              done;
  logic              in_we;
  logic [7:0]        in_addr;
  logic [DATA_W-1:0] in_data;
  logic              wbm_cyc_o;
  logic              wbm_stb_o;
  logic              wbm_we_o;
  logic [3:0]        wbm_sel_o;
  logic [31:0]       wbm_adr_o;
  logic [31:0]       wbm_dat_i;
  logic              wbm_ack_i;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [7:0]        out_idx;

  typedef struct packed {
    logic [7:0]  idx;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] wmem [16];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          ack_wait = 1;
  int          wait_cnt = 0;
  int          rd_idx   = 0;
  int          rd_cnt   = 0;
  int          done_cnt = 0;

  linear_layer_engine #(
    .DATA_W(DATA_W), .FRAC_W(24), .IN_LEN(IN_LEN), .OUT_LEN(OUT_LEN),
    .GUARD_W(8), .WEIGHT_BASE(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .in_we(in_we), .in_addr(in_addr), .in_data(in_data),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_i(wbm_dat_i),
    .wbm_ack_i(wbm_ack_i), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Wishbone slave: acks ack_wait cycles after the request, checks addressing
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbm_ack_i = 1'b0;
      wait_cnt  = 0;
      rd_idx    = 0;
    end else begin
      int o;
      int j;
      int exp_adr;
      if (start && !busy) rd_idx = 0;
      if (wbm_cyc_o && wbm_stb_o && !wbm_ack_i) begin
        if (wait_cnt >= ack_wait) begin
          o = rd_idx / RD_PER_OUT;
          j = rd_idx % RD_PER_OUT;
          exp_adr = (j < IN_LEN) ? (o * IN_LEN + j) : (OUT_LEN * IN_LEN + o);
          check("wb_adr", 64'(wbm_adr_o), 64'(exp_adr));
          check("wb_sel_we", {59'd0, wbm_sel_o, wbm_we_o}, {59'd0, 4'hF, 1'b0});
          wbm_dat_i = wmem[wbm_adr_o[3:0]];
          wbm_ack_i = 1'b1;
          wait_cnt  = 0;
          rd_idx++;
          rd_cnt++;
        end else begin
          wait_cnt++;
        end
      end else begin
        wbm_ack_i = 1'b0;
      end
    end
  end

  // Monitor: compares every valid cycle against the scoreboard head, pops on handshake
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) done_cnt++;
      if (out_valid) begin
        check("no_req_while_valid", 64'(wbm_stb_o), 64'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_output", 64'd1, 64'd0);
        end else begin
          check("out_data", 64'(out_data), 64'(exp_q[0].data));
          check("out_idx", 64'(out_idx), 64'(exp_q[0].idx));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_inputs(input logic [31:0] v0, input logic [31:0] v1,
                             input logic [31:0] v2, input logic [31:0] v3);
    logic [31:0] vals [4];
    vals[0] = v0; vals[1] = v1; vals[2] = v2; vals[3] = v3;
    for (int k = 0; k < 4; k++) begin
      in_we = 1'b1; in_addr = 8'(k); in_data = vals[k];
      tick();
    end
    in_we = 1'b0;
  endtask

  task automatic fill_w(input logic [31:0] row0, input logic [31:0] row1);
    for (int k = 0; k < IN_LEN; k++) begin
      wmem[k]          = row0;
      wmem[IN_LEN + k] = row1;
    end
  endtask

  // mode 0: plain, 1: backpressure at first output, 2: start/in_we pokes while busy
  task automatic run_layer(input string name, input logic [31:0] e0,
                           input logic [31:0] e1, input int mode);
    int d0;
    int r0;
    d0 = done_cnt;
    r0 = rd_cnt;
    exp_q.push_back({8'd0, e0});
    exp_q.push_back({8'd1, e1});
    if (mode == 1) out_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    if (mode == 1) begin
      for (int c = 0; c < 500 && !out_valid; c++) tick();
      repeat (5) tick();
      out_ready = 1'b1;
    end
    if (mode == 2) begin
      repeat (6) tick();
      start = 1'b1; in_we = 1'b1; in_addr = 8'd0; in_data = 32'h7F00_0000;
      tick();
      start = 1'b0; in_we = 1'b0;
    end
    for (int c = 0; c < 4000 && done_cnt == d0; c++) tick();
    repeat (3) tick();
    check({name, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
    check({name, "_wb_reads"}, 64'(rd_cnt - r0), 64'(OUT_LEN * RD_PER_OUT));
    check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    check({name, "_idle"}, {62'd0, busy, out_valid}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    rst_n = 1'b0; start = 1'b0; in_we = 1'b0; in_addr = '0; in_data = '0;
    out_ready = 1'b1; wbm_dat_i = '0; wbm_ack_i = 1'b0;
    for (int k = 0; k < 16; k++) wmem[k] = '0;
    wmem[8] = 32'h0100_0000;
    wmem[9] = 32'h0100_0000;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    check("rst_ctrl", {60'd0, busy, done, out_valid, wbm_we_o}, 64'd0);
    check("rst_wb", {58'd0, wbm_cyc_o, wbm_stb_o, wbm_sel_o}, 64'd0);
    check("rst_adr", 64'(wbm_adr_o), 64'd0);
    check("rst_out", {24'd0, out_idx, out_data}, 64'd0);

    // 1.0 * 0.5 summed over four inputs = 2.0; out-of-range write must not alias
    load_inputs(32'h0100_0000, 32'h0100_0000, 32'h0100_0000, 32'h0100_0000);
    in_we = 1'b1; in_addr = 8'd4; in_data = 32'h7F00_0000;
    tick();
    in_we = 1'b0;
    fill_w(32'h0080_0000, 32'h0080_0000);
    run_layer("basic", 32'h0200_0000 + BIAS_ADD, 32'h0200_0000 + BIAS_ADD, 0);

    // Distinct rows: 4 x 0.5 = 2.0 and 4 x 0.25 = 1.0
    fill_w(32'h0080_0000, 32'h0040_0000);
    run_layer("rows", 32'h0200_0000 + BIAS_ADD, 32'h0100_0000 + BIAS_ADD, 0);

    fill_w(32'h0080_0000, 32'h0080_0000);
    run_layer("backpressure", 32'h0200_0000 + BIAS_ADD, 32'h0200_0000 + BIAS_ADD, 1);

    ack_wait = 3;
    run_layer("slow_ack", 32'h0200_0000 + BIAS_ADD, 32'h0200_0000 + BIAS_ADD, 0);
    ack_wait = 1;

    run_layer("busy_pokes", 32'h0200_0000 + BIAS_ADD, 32'h0200_0000 + BIAS_ADD, 2);

    // -1.0 * 0.25 x 4 = -1.0
    load_inputs(32'hFF00_0000, 32'hFF00_0000, 32'hFF00_0000, 32'hFF00_0000);
    fill_w(32'h0040_0000, 32'h0040_0000);
    run_layer("negative", 32'hFF00_0000 + BIAS_ADD, 32'hFF00_0000 + BIAS_ADD, 0);

    // 1 lsb * 1 lsb truncates to 0; -1 lsb * 1 lsb floors to -1 lsb per term
    load_inputs(32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h0000_0001);
    fill_w(32'h0000_0001, 32'h0000_0001);
    run_layer("trunc_pos", 32'h0000_0000 + BIAS_ADD, 32'h0000_0000 + BIAS_ADD, 0);
    load_inputs(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_layer("trunc_neg", 32'hFFFF_FFFC + BIAS_ADD, 32'hFFFF_FFFC + BIAS_ADD, 0);

    // Two 100.0 inputs: +/-20000.0 saturates (four such terms would wrap 40 bits)
    load_inputs(32'h6400_0000, 32'h6400_0000, 32'h0000_0000, 32'h0000_0000);
    fill_w(32'h6400_0000, 32'h6400_0000);
    run_layer("sat_pos", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0);
    fill_w(32'h9C00_0000, 32'h9C00_0000);
    run_layer("sat_neg", 32'h8000_0000, 32'h8000_0000, 0);

    // Abort with reset during the second weight fetch of output 1
    load_inputs(32'h0100_0000, 32'h0100_0000, 32'h0100_0000, 32'h0100_0000);
    fill_w(32'h0080_0000, 32'h0080_0000);
    exp_q.push_back({8'd0, 32'h0200_0000 + BIAS_ADD});
    exp_q.push_back({8'd1, 32'h0200_0000 + BIAS_ADD});
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 2000 && !(rd_idx == RD_PER_OUT + 1 && wbm_stb_o); c++) tick();
    check("abort_reached_fetch", 64'(rd_idx), 64'(RD_PER_OUT + 1));
    d0 = done_cnt;
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_async", {61'd0, wbm_cyc_o, wbm_stb_o, out_valid}, 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("abort_no_done", 64'(done_cnt - d0), 64'd0);
    run_layer("after_abort", 32'h0200_0000 + BIAS_ADD, 32'h0200_0000 + BIAS_ADD, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
